// File: rtl/tl45_pkg.sv
// Shared types and constants for the TL45 instruction prefetch path.
package tl45_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_HALT_ERR = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FIFO_W   = 65;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } buf_entry_t;

endpackage

// File: rtl/tl45_sync_fifo.sv
// Synchronous FIFO with registered full/empty/count; head is read straight from storage.
// Push into a full FIFO is dropped unless a pop happens in the same cycle.
module tl45_sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q, count_d;
  logic             empty_q, full_q, do_push, do_pop;

  always_comb begin
    do_pop  = pop & ~empty_q;
    do_push = push & (~full_q | do_pop);
    count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == FULL_CNT);
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;

endmodule

// File: rtl/tl45_prefetch_pipe.sv
// Pipelined-Wishbone instruction prefetcher: issues word reads while FIFO space plus
// outstanding requests stay under DEPTH; ack lands in the head FIFO one cycle later.
module tl45_prefetch_pipe
  import tl45_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_pipe_stall,
  input  logic          i_new_pc,
  input  logic [31:0]   i_pc,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  output logic [3:0]    o_wb_sel,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic          i_wb_stall,
  input  logic [31:0]   i_wb_data,
  output logic          o_buf_valid,
  output logic [31:0]   o_buf_pc,
  output logic [31:0]   o_buf_inst,
  output logic          o_buf_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic          cyc_q, cyc_d, stb_q, stb_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   req_pc_q, req_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;

  logic [CW-1:0] fifo_cnt, cnt_nxt;
  logic [CW:0]   load;
  logic          fifo_full, fifo_empty;
  logic          issue, rsp_ok, ack_v, err_v, push, pop, credit;
  buf_entry_t    push_ent, head_ent;
  logic          unused_pc_lsb;

  assign unused_pc_lsb = &{1'b0, i_pc[1:0]};

  always_comb begin
    issue    = stb_q & ~i_wb_stall;
    rsp_ok   = cyc_q & (outst_q != '0);
    ack_v    = rsp_ok & i_wb_ack & ~i_wb_err;
    err_v    = rsp_ok & i_wb_err;
    pop      = ~fifo_empty & ~i_pipe_stall;
    push     = (ack_v | err_v) & ~i_new_pc & (~fifo_full | pop);
    push_ent = '{pc: resp_pc_q, inst: (err_v ? 32'h0 : i_wb_data), err: err_v};

    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    req_pc_d  = req_pc_q + (issue ? 32'd4 : 32'd0);
    resp_pc_d = resp_pc_q + (ack_v ? 32'd4 : 32'd0);
    outst_d   = outst_q + CW'(issue) - CW'(ack_v);

    // Credit looks at next-cycle occupancy so stb is only ever raised for a slot that exists.
    cnt_nxt = fifo_cnt + CW'(push) - CW'(pop);
    load    = {1'b0, cnt_nxt} + {1'b0, outst_d};
    credit  = (load < LIMIT);

    if (i_new_pc) begin
      state_d   = ST_IDLE;
      cyc_d     = 1'b0;
      stb_d     = 1'b0;
      outst_d   = '0;
      req_pc_d  = {i_pc[31:2], 2'b00};
      resp_pc_d = {i_pc[31:2], 2'b00};
    end else begin
      case (state_q)
        ST_IDLE: begin
          cyc_d = credit;
          stb_d = credit;
          if (credit) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (err_v) begin
            state_d = ST_HALT_ERR;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            outst_d = '0;
          end else begin
            stb_d = credit;
            cyc_d = credit | (outst_d != '0);
            if (!(credit | (outst_d != '0))) state_d = ST_IDLE;
          end
        end
        default: begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          outst_d = '0;
        end
      endcase
    end

    addr_d = req_pc_d[AW+1:2];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      addr_q    <= '0;
      req_pc_q  <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      addr_q    <= addr_d;
      req_pc_q  <= req_pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
    end
  end

  tl45_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .flush    (i_new_pc),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = 1'b0;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = 32'h0;
  assign o_wb_sel    = 4'hF;
  assign o_buf_valid = ~fifo_empty;
  assign o_buf_pc    = head_ent.pc;
  assign o_buf_inst  = head_ent.inst;
  assign o_buf_err   = head_ent.err;

endmodule

// File: tb/tb_tl45_prefetch_pipe.sv
// Directed bench for tl45_prefetch_pipe with a one-cycle-latency pipelined Wishbone slave.
module tb_tl45_prefetch_pipe;
  localparam int DEPTH = 4;
  localparam int AW    = 30;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_pipe_stall = 1'b0;
  logic          i_new_pc = 1'b0;
  logic [31:0]   i_pc = 32'h0;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [31:0]   o_wb_data;
  logic [3:0]    o_wb_sel;
  logic          i_wb_ack = 1'b0, i_wb_err = 1'b0, i_wb_stall = 1'b0;
  logic [31:0]   i_wb_data = 32'h0;
  logic          o_buf_valid, o_buf_err;
  logic [31:0]   o_buf_pc, o_buf_inst;

  tl45_prefetch_pipe #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_pipe_stall (i_pipe_stall),
    .i_new_pc     (i_new_pc),
    .i_pc         (i_pc),
    .o_wb_cyc     (o_wb_cyc),
    .o_wb_stb     (o_wb_stb),
    .o_wb_we      (o_wb_we),
    .o_wb_addr    (o_wb_addr),
    .o_wb_data    (o_wb_data),
    .o_wb_sel     (o_wb_sel),
    .i_wb_ack     (i_wb_ack),
    .i_wb_err     (i_wb_err),
    .i_wb_stall   (i_wb_stall),
    .i_wb_data    (i_wb_data),
    .o_buf_valid  (o_buf_valid),
    .o_buf_pc     (o_buf_pc),
    .o_buf_inst   (o_buf_inst),
    .o_buf_err    (o_buf_err)
  );

  always #5 i_clk = ~i_clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_issue = 0;
  logic [AW-1:0] q[$];
  logic          ack_hold = 1'b0;
  logic [AW-1:0] err_addr = '1;
  logic [31:0]   got[$];

  function automatic logic [31:0] inst_of(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {2'b00, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave accepts on stb&!stall, answers the cycle after, forgets everything once cyc drops.
  always begin : wb_slave
    logic [AW-1:0] a;
    @(negedge i_clk);
    #4;
    if (!i_reset_n || !o_wb_cyc) q.delete();
    else if (o_wb_stb && !i_wb_stall) begin
      q.push_back(o_wb_addr);
      n_issue++;
    end
    @(posedge i_clk);
    #1;
    i_wb_ack  = 1'b0;
    i_wb_err  = 1'b0;
    i_wb_data = 32'h0;
    if (!o_wb_cyc) q.delete();
    else if (!ack_hold && q.size() > 0) begin
      a = q.pop_front();
      if (a == err_addr) i_wb_err = 1'b1;
      else begin
        i_wb_ack  = 1'b1;
        i_wb_data = inst_of(a);
      end
    end
  end

  task automatic tick;
    @(negedge i_clk);
  endtask

  task automatic tick_rec;
    @(negedge i_clk);
    if (o_buf_valid && !i_pipe_stall) got.push_back(o_buf_pc);
  endtask

  task automatic redirect(input logic [31:0] pc);
    i_new_pc = 1'b1;
    i_pc     = pc;
    tick();
    i_new_pc = 1'b0;
  endtask

  task automatic wait_stb(input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (o_wb_stb) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    bit found;
    int base;

    // Reset state
    tick();
    check("rst_cyc", o_wb_cyc, 0);
    check("rst_stb", o_wb_stb, 0);
    check("rst_addr", o_wb_addr, 0);
    check("rst_valid", o_buf_valid, 0);
    check("rst_pc", o_buf_pc, 0);
    check("rst_inst", o_buf_inst, 0);
    check("rst_err", o_buf_err, 0);
    check("we_const", o_wb_we, 0);
    check("sel_const", o_wb_sel, 4'hF);
    check("data_const", o_wb_data, 0);

    // Back-to-back fetch from reset
    i_reset_n = 1'b1;
    tick();
    check("b2b_stb0", o_wb_stb, 1);
    check("b2b_addr0", o_wb_addr, 0);
    tick();
    check("b2b_addr1", o_wb_addr, 1);
    tick();
    check("b2b_valid", o_buf_valid, 1);
    check("b2b_pc0", o_buf_pc, 32'h0);
    check("b2b_inst0", o_buf_inst, 32'hC0DE_0000);
    tick();
    check("b2b_pc4", o_buf_pc, 32'h4);
    tick();
    check("b2b_pc8", o_buf_pc, 32'h8);
    tick();
    check("b2b_pcC", o_buf_pc, 32'hC);
    check("b2b_instC", o_buf_inst, 32'hC0DE_0003);

    // Bus stall on second request
    redirect(32'h0);
    check("stl_redir_cyc", o_wb_cyc, 0);
    got.delete();
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (o_wb_stb && o_wb_addr == 1) begin
        found = 1'b1;
        break;
      end
      tick_rec();
    end
    check("stl_found", found, 1);
    i_wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stl_addr_hold", o_wb_addr, 1);
      check("stl_stb_hold", o_wb_stb, 1);
      tick_rec();
    end
    i_wb_stall = 1'b0;
    repeat (14) tick_rec();
    check("stl_count", (got.size() >= 6), 1);
    for (int i = 0; i < 6 && i < got.size(); i++) check("stl_seq", got[i], 32'(4 * i));

    // Redirect with two requests outstanding
    ack_hold = 1'b1;
    redirect(32'h40);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (q.size() == 2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("rd_two_outst", found, 1);
    i_wb_stall = 1'b1;
    ack_hold   = 1'b0;
    tick();
    check("rd_stale_ack", i_wb_ack, 1);
    i_wb_stall = 1'b0;
    redirect(32'h103);
    check("rd_cyc_low", o_wb_cyc, 0);
    check("rd_flushed", o_buf_valid, 0);
    tick();
    check("rd_cyc_back", o_wb_cyc, 1);
    check("rd_addr", o_wb_addr, 30'h40);
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (o_buf_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("rd_valid", found, 1);
    check("rd_pc", o_buf_pc, 32'h100);
    check("rd_inst", o_buf_inst, 32'hC0DE_0040);

    // Consumer stalled: credit limit
    i_pipe_stall = 1'b1;
    redirect(32'h0);
    base = n_issue;
    repeat (10) tick();
    check("cr_issued4", n_issue - base, 4);
    check("cr_stb_low", o_wb_stb, 0);
    check("cr_valid", o_buf_valid, 1);
    check("cr_head", o_buf_pc, 32'h0);
    tick();
    check("cr_still4", n_issue - base, 4);
    i_pipe_stall = 1'b0;
    tick();
    i_pipe_stall = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (n_issue - base == 5) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("cr_fifth", found, 1);
    check("cr_head_after_pop", o_buf_pc, 32'h4);

    // Bus error on PC 8
    err_addr = 30'h2;
    redirect(32'h0);
    repeat (8) tick();
    check("er_cyc", o_wb_cyc, 0);
    check("er_stb", o_wb_stb, 0);
    base = n_issue;
    repeat (5) tick();
    check("er_no_issue", n_issue - base, 0);
    check("er_h0_pc", o_buf_pc, 32'h0);
    check("er_h0_err", o_buf_err, 0);
    i_pipe_stall = 1'b0;
    tick();
    check("er_h1_pc", o_buf_pc, 32'h4);
    check("er_h1_err", o_buf_err, 0);
    tick();
    check("er_h2_valid", o_buf_valid, 1);
    check("er_h2_pc", o_buf_pc, 32'h8);
    check("er_h2_err", o_buf_err, 1);
    check("er_h2_inst", o_buf_inst, 0);
    tick();
    check("er_drained", o_buf_valid, 0);
    err_addr = '1;
    redirect(32'h200);
    wait_stb(6, found);
    check("er_restart", found, 1);
    check("er_restart_addr", o_wb_addr, 30'h80);

    // Asynchronous reset mid-burst
    repeat (4) tick();
    check("ar_pre_valid", o_buf_valid, 1);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("ar_cyc", o_wb_cyc, 0);
    check("ar_stb", o_wb_stb, 0);
    check("ar_addr", o_wb_addr, 0);
    check("ar_valid", o_buf_valid, 0);
    check("ar_pc", o_buf_pc, 0);
    tick();
    i_reset_n = 1'b1;
    wait_stb(6, found);
    check("ar_restart", found, 1);
    check("ar_first_addr", o_wb_addr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tl45_prefetch_pipe.md
TL45_PREFETCH_PIPE -- requirements
Module: tl45_prefetch_pipe

Interface
REQ-001 Parameter DEPTH, default 4: instruction FIFO entries and outstanding-request limit; power of two, 2..16.
REQ-002 Parameter AW, default 30: word-address width; fetch PC bits [AW+1:2] drive the bus.
REQ-003 i_clk  in  1  single system clock, all state on rising edge.
REQ-004 i_reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_pipe_stall  in  1  downstream holds the head entry; no pop while high.
REQ-006 i_new_pc  in  1  redirect strobe; takes priority over every other event.
REQ-007 i_pc  in  32  redirect target, sampled when i_new_pc=1; bits [1:0] ignored.
REQ-008 o_wb_cyc  out  1  Wishbone cycle, registered.
REQ-009 o_wb_stb  out  1  Wishbone strobe, registered.
REQ-010 o_wb_we  out  1  constant 0.
REQ-011 o_wb_addr  out  AW  word address of the request on the bus.
REQ-012 o_wb_data  out  32  constant 0.
REQ-013 o_wb_sel  out  4  constant 4'hF.
REQ-014 i_wb_ack, i_wb_err, i_wb_stall  in  1 each  pipelined-Wishbone responses and stall.
REQ-015 i_wb_data  in  32  read data, valid with i_wb_ack.
REQ-016 o_buf_valid  out  1  FIFO head is valid.
REQ-017 o_buf_pc, o_buf_inst  out  32 each  byte PC and instruction of the head entry.
REQ-018 o_buf_err  out  1  head entry is a bus-error marker; o_buf_inst=0 with it.

Function
REQ-019 States: IDLE, FETCH, HALT_ERR; every output is registered.
REQ-020 Request issue (stb=1 and !i_wb_stall) is accepted only when fifo_count + outstanding < DEPTH; an accepted request advances req_pc by 4.
REQ-021 While stb=1 and i_wb_stall=1, address and stb hold.
REQ-022 Each ack pushes {pc, i_wb_data, err=0}, PCs in issue order; the return PC comes from a separate resp_pc counter.
REQ-023 Pop occurs when o_buf_valid=1 and i_pipe_stall=0; push and pop in the same cycle leave the count unchanged; full and empty flags are exact.
REQ-024 IDLE->FETCH when credit exists; in FETCH, cyc=1 while outstanding>0 or an issue is pending.
REQ-025 FETCH->IDLE when outstanding=0 and credit is zero; cyc drops that cycle.
REQ-026 Ack-to-o_buf_valid latency is 1 cycle into an empty FIFO.
REQ-027 i_wb_err: push an error marker {resp_pc, 0, err=1}, drop cyc and stb next cycle, discard all other outstanding responses, and enter HALT_ERR; no issue until a redirect.
REQ-028 i_new_pc: flush the FIFO, zero outstanding, deassert cyc and stb next cycle, and set req_pc=resp_pc={i_pc[31:2],2'b00}; go to IDLE; acks in that cycle are discarded.
REQ-029 Fetching resumes no earlier than 1 cycle after the redirect, so cyc is low for at least 1 cycle, which aborts the bus.
REQ-030 The ack and err counter updates cannot underflow; an ack with outstanding=0 is ignored.
REQ-031 req_pc wraps from 32'hFFFFFFFC to 0 without flagging.

Reset
REQ-032 On i_reset_n=0, asynchronously: state=IDLE, cyc=stb=0, o_wb_addr=0, req_pc=resp_pc=0, FIFO empty, o_buf_valid=0, o_buf_pc=o_buf_inst=0, o_buf_err=0.
REQ-033 Reset asserted mid-burst abandons every request; the first request after release is to address 0.

Structure
REQ-034 The state enum and the reset PC constant (32'h0) belong in package tl45_pkg.
REQ-035 The FIFO is sub-module tl45_sync_fifo, with parameters WIDTH=65 and DEPTH, and ports push, pop, full, empty, count.

Verification
REQ-036 Reset release, ack every cycle, stall=0: requests to words 0,1,2,3 back to back; o_buf_pc is 0,4,8,C on consecutive cycles.
REQ-037 i_pipe_stall held high: exactly 4 requests issue, stb then drops, the FIFO is full, and the 5th request issues only after a pop.
REQ-038 i_wb_stall=1 for 3 cycles on the 2nd request: o_wb_addr holds at 1 and no PC is skipped or duplicated.
REQ-039 i_new_pc with i_pc=32'h100 while 2 requests are outstanding: the FIFO empties, cyc is low 1 cycle, the stale acks are dropped, and the next head has o_buf_pc=32'h100.
REQ-040 i_wb_err on PC 8: the head after 0 and 4 has o_buf_err=1 and o_buf_pc=8, no further stb occurs, and a redirect restarts fetching.
REQ-041 i_reset_n pulsed low mid-burst: outputs clear immediately without a clock edge.
